// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle for the ALU to settle on the
// registered operands, then a held response to the granted port.
//
// Handshakes: a transfer on any valid/ready pair happens on a rising clk edge
// where both valid and ready are high. A requester holds valid and payload
// stable until ready; the arbiter holds resp valid/result/zero stable until
// the owner's resp ready.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0 (execute-stage sequencer)
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  // requester 1 (address/branch-compare unit)
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero,
  // ALU side
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  // FSM state for observation
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;

  logic              grant_valid;
  logic              grant_port;
  logic              resp_fire;

  // Round-robin grant; only offered in IDLE and never while reset is applied.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_port  = ~last_grant;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_port  = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_port  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_port;
  assign req1_ready = grant_valid && grant_port;

  // Only the owner's resp ready can close the response; the other is ignored.
  assign resp_fire = (state == RESP) && (owner ? resp1_ready : resp0_ready);

  assign resp0_valid  = (state == RESP) && !owner;
  assign resp1_valid  = (state == RESP) && owner;
  assign resp0_result = result_q;
  assign resp1_result = result_q;
  assign resp0_zero   = zero_q;
  assign resp1_zero   = zero_q;
  assign dbg_state    = state;

  // Sequencer: operand capture on grant, result capture after EXEC, response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            alu_a      <= grant_port ? req1_a   : req0_a;
            alu_b      <= grant_port ? req1_b   : req0_b;
            alu_sel    <= grant_port ? req1_sel : req0_sel;
            owner      <= grant_port;
            last_grant <= grant_port;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_out;
          zero_q   <= alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (resp_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized transactions against a
// transaction-level model (grant order, expected result per operation).
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
  logic [DW-1:0] req0_a, req0_b, resp0_result;
  logic [SW-1:0] req0_sel;
  logic          req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
  logic [DW-1:0] req1_a, req1_b, resp1_result;
  logic [SW-1:0] req1_sel;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [SW-1:0] alu_sel;
  logic          alu_zero;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic last_grant_m;          // port that won the previous grant
  logic [DW-1:0] exp_q[$];

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  alu_arbiter #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_zero(resp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_zero(alu_zero),
    .dbg_state(dbg_state)
  );

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra, else add
  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [SW-1:0] sel);
    case (sel)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return $unsigned($signed(a) >>> b[4:0]);
      default: return a + b;
    endcase
  endfunction

  // external ALU instance
  always_comb begin
    alu_out  = alu_ref(alu_a, alu_b, alu_sel);
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench just after a rising edge with reset released (IDLE).
  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    last_grant_m = 1'b1;
  endtask

  // One full operation. Entered and left just after a rising edge.
  task automatic issue(input logic v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic [SW-1:0] s0,
                       input logic v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                       input logic [SW-1:0] s1, input int hold);
    logic          port;
    logic [DW-1:0] ea, eb, er;
    logic [SW-1:0] es;
    int            waited;
    port = (v0 && v1) ? ~last_grant_m : v1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
    @(negedge clk);
    check("idle_resp_valid", {30'd0, resp1_valid, resp0_valid}, 0);
    waited = 0;
    while (!(req0_ready || req1_ready) && waited < 8) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    check("accept_wait", waited, 0);
    check("req0_ready", req0_ready, !port);
    check("req1_ready", req1_ready, port);
    ea = port ? a1 : a0;
    eb = port ? b1 : b0;
    es = port ? s1 : s0;
    er = alu_ref(ea, eb, es);
    last_grant_m = port;
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    // execute cycle
    @(negedge clk);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_sel", alu_sel, es);
    check("exec_resp_valid", {30'd0, resp1_valid, resp0_valid}, 0);
    check("exec_req_ready", {30'd0, req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    if (port) begin
      resp1_ready = (hold == 0); resp0_ready = 1'($urandom_range(0, 1));
    end else begin
      resp0_ready = (hold == 0); resp1_ready = 1'($urandom_range(0, 1));
    end
    // first response cycle, then any held cycles
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i == hold) begin
          if (port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        end
      end
      @(negedge clk);
      check("resp0_valid", resp0_valid, !port);
      check("resp1_valid", resp1_valid, port);
      check("resp_result", port ? resp1_result : resp0_result, er);
      check("resp_zero", port ? resp1_zero : resp0_zero, (er == '0));
      check("resp_req_ready", {30'd0, req1_ready, req0_ready}, 0);
    end
    @(posedge clk); #1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  initial begin
    int last_acc;
    int cyc;
    logic acc;
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    resp0_ready = 0; resp1_ready = 0;
    last_grant_m = 1'b1;

    // reset values
    do_reset();
    @(negedge clk);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_alu_sel", alu_sel, 0);
    check("reset_resp_valid", {30'd0, resp1_valid, resp0_valid}, 0);
    check("reset_result", resp0_result, 0);
    check("reset_zero", resp0_zero, 0);
    check("reset_ready_idle", {30'd0, req1_ready, req0_ready}, 0);
    @(posedge clk); #1;

    // single request on port 0: 5 - 3
    issue(1, 5, 3, 4'd1, 0, 0, 0, 4'd0, 0);

    // ties after reset: port 0, then port 1, then port 0 again
    do_reset();
    issue(1, 7, 7, 4'd1, 1, 32'h0000_00F0, 4, 4'd7, 0);
    issue(1, $urandom, $urandom, 4'($urandom_range(0, 8)), 1, 32'h0000_00F0, 4, 4'd7, 0);
    issue(1, $urandom, $urandom, 4'($urandom_range(0, 8)), 1, $urandom, $urandom, 4'd2, 0);

    // response held off 4 cycles while the other port keeps requesting
    do_reset();
    issue(1, $urandom, $urandom, 4'd4, 1, $urandom, $urandom, 4'd3, 4);
    issue(0, 0, 0, 4'd0, 1, 32'hFFFF_FFF0, 2, 4'd8, 0);
    issue(0, 0, 0, 4'd0, 1, 3, 4, 4'd15, 0);

    // reset during EXEC discards the operation
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_sel = 4'd0;
    @(negedge clk);
    check("pre_rst_accept", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_grant_m = 1'b1;
    @(negedge clk);
    check("rst_exec_alu_a", alu_a, 0);
    check("rst_exec_alu_b", alu_b, 0);
    check("rst_exec_alu_sel", alu_sel, 0);
    for (int i = 0; i < 4; i++) begin
      check("rst_exec_no_resp", {30'd0, resp1_valid, resp0_valid}, 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    issue(1, 1, 2, 4'd0, 0, 0, 0, 4'd0, 0);

    // randomized operations
    for (int n = 0; n < 24; n++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      issue(v0, $urandom, $urandom, 4'($urandom_range(0, 15)),
            v1, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    // back-to-back on port 0 with the response always consumed
    req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_sel = 4'($urandom_range(0, 8));
    req1_valid = 0; resp0_ready = 1; resp1_ready = 0;
    last_acc = -1;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      acc = req0_ready;
      check("b2b_overlap", {31'd0, req0_ready & resp0_valid}, 0);
      if (resp0_valid) begin
        if (exp_q.size() == 0) check("b2b_unexpected_resp", 1, 0);
        else check("b2b_result", resp0_result, exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(alu_ref(req0_a, req0_b, req0_sel));
        if (last_acc >= 0) check("b2b_interval", cyc - last_acc, 3);
        last_acc = cyc;
      end
      @(posedge clk); #1;
      if (acc) begin
        req0_a = $urandom; req0_b = $urandom; req0_sel = 4'($urandom_range(0, 15));
      end
    end
    req0_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp0_valid && exp_q.size() > 0) check("b2b_drain", resp0_result, exp_q.pop_front());
      @(posedge clk); #1;
    end
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_acceptances", (last_acc >= 27) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters with a valid/ready handshake: port 0 is the execute-stage sequencer, port 1 is the address/branch-compare unit.
- Arbitrates round-robin and registers the winning operands onto the ALU inputs.
- Captures the ALU result and zero flag, then returns them to the granted requester over a held response handshake.
- Sits between the control unit and the ALU instance in the datapath.

Parameters:
DATA_W, 32, operand/result width (matches ALU a, b, alu_out)
SEL_W, 4, ALU operation select width (matches ALU alu_sel encoding)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  DATA_W  requester 0 operand a
req0_b  input  DATA_W  requester 0 operand b
req0_sel  input  SEL_W  requester 0 ALU op (0000 add … 1000 sra)
resp0_valid  output  1  result for requester 0 available
resp0_ready  input  1  requester 0 consumes result
resp0_result  output  DATA_W  captured alu_out
resp0_zero  output  1  captured zero flag
req1_valid / req1_ready / req1_a / req1_b / req1_sel  same as port 0, requester 1
resp1_valid / resp1_ready / resp1_result / resp1_zero  same as port 0, requester 1
alu_a  output  DATA_W  registered operand a to ALU
alu_b  output  DATA_W  registered operand b to ALU
alu_sel  output  SEL_W  registered op select to ALU
alu_out  input  DATA_W  ALU result
alu_zero  input  1  ALU zero flag

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- FSM states are IDLE, EXEC, RESP. Register owner (1 bit) and last_grant (1 bit).
- Reset values:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), owner=0.
  - alu_a=0, alu_b=0, alu_sel=0000.
  - result register=0, zero register=0.
  - all resp*_valid=0, all req*_ready=0.
- Grant (combinational, IDLE only):
  - If only one reqN_valid is high, that port is granted.
  - If both are high, grant the port != last_grant.
  - If neither is high, no grant.
  - reqN_ready = (state==IDLE) && granted==N. It is never high outside IDLE. It is never high for both ports in the same cycle.
- IDLE -> EXEC on any grant. At that edge:
  - Load alu_a/alu_b/alu_sel from the granted port.
  - owner<=granted, last_grant<=granted.
- EXEC lasts exactly 1 cycle; the ALU settles combinationally on the registered operands. At the end of EXEC:
  - result<=alu_out, zero<=alu_zero.
  - state<=RESP.
- RESP:
  - resp[owner]_valid=1. The other port's resp_valid=0.
  - resp*_result/zero present the captured values; they are stable until the handshake completes.
  - On resp[owner]_ready=1 -> IDLE next cycle. If ready is already high in the first RESP cycle, stay in RESP exactly 1 cycle.
  - The non-owner's resp_ready is ignored.
- Latency: acceptance edge T; EXEC is cycle T+1; resp_valid first high in cycle T+2. Minimum issue interval is 3 cycles per operation.
- alu_a/b/sel hold their last values in RESP and IDLE; they update only on a grant.
- resp*_result/zero outputs hold their last values after the handshake. resp*_valid is the only qualifier.
- Requests arriving during EXEC/RESP are not accepted (ready=0). The requester holds valid and operands stable until ready.
- A dropped valid before acceptance is legal; no state change.
- Unused/undefined sel codes (1001–1111) are forwarded unchanged. The ALU applies its default (add).
- rst asserted in any state, including mid-EXEC or RESP with the response unconsumed: next cycle all reset values apply and the in-flight operation is discarded with no resp_valid.
- Requesters re-arbitrate from IDLE after reset, with port 0 winning ties.

Test Plan:
- Reset, then req0 {a=5, b=3, sel=0001} alone → req0_ready=1 in the request cycle; alu_a=5/alu_b=3/alu_sel=0001 next cycle; resp0_valid in cycle +2 with result=2, zero=0; resp1_valid stays 0.
- Both ports valid after reset: req0 {7, 7, sub}, req1 {0x0000_00F0, 4, srl} → port 0 granted first (result=0, zero=1); after resp0 handshake, port 1 granted (result=0x0000_000F); third tie goes to port 0.
- resp0_ready held low 4 cycles in RESP → resp0_valid and result stay stable; req1_valid high throughout but req1_ready=0 until IDLE.
- req1 {0xFFFF_FFF0, 2, sel=1000} with an external signed ALU model → result=0xFFFF_FFFC; sel=1111 {3, 4} → result=7.
- rst pulsed during EXEC of req0 {1, 2, add} → no resp0_valid ever appears; alu_a/b/sel=0 next cycle; a subsequent req0 completes normally with 3-cycle latency.
- Back-to-back: req0 valid continuously with resp0_ready=1 → acceptances exactly every 3 cycles; req0_ready and resp0_valid never high in the same cycle.
